// File: rtl/pcs_tx_gearbox.sv
// pcs_tx_gearbox
//
// Per-lane 66b-to-64b transmit gearbox between the PCS encoder/scrambler/
// alignment-marker stage and the PMA serializer. Each accepted cycle takes
// one block per lane (sync header in the LSBs, scrambled payload above it).
// Every cycle it emits one DATA_W-bit word per lane, with bit 0 sent first.
//
// One sequence counter is shared by all lanes, so the lanes stay
// word-aligned to each other. The counter runs 0..DATA_W/HEAD_W (0..32 with
// the default widths). On the final count the gearbox takes no input. It
// drains the residual bits it has collected instead. That is why ready_o
// drops for one cycle in every 33.
//
// Ports:
//   clk      clock
//   nreset   synchronous, active-high reset
//   head_i   sync header per lane; lane i uses bits [i*HEAD_W +: HEAD_W]
//   data_i   scrambled payload per lane; lane i uses [i*DATA_W +: DATA_W]
//   ready_o  head_i/data_i are accepted this cycle
//   data_o   PMA word per lane; lane i uses [i*DATA_W +: DATA_W]
//   valid_o  data_o carries gearbox data (low only straight out of reset)
//   seq_o    current sequence count, for debug and alignment visibility
//
// SEQ_W must be wide enough to hold DATA_W/HEAD_W (2^SEQ_W > 32 by default).

module pcs_tx_gearbox #(
  parameter int LANE_N = 4,
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2,
  parameter int SEQ_W  = 6
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic [LANE_N*DATA_W-1:0] data_o,
  output logic                     valid_o,
  output logic [SEQ_W-1:0]         seq_o
);

  localparam int BLK_W = DATA_W + HEAD_W;
  localparam int TMP_W = 2 * DATA_W;
  localparam int SEQ_LAST_I = DATA_W / HEAD_W;
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_LAST_I);

  logic [SEQ_W-1:0]         seq_q;
  logic [SEQ_W-1:0]         seq_d;
  logic                     ready_q;
  logic                     ready_d;
  logic                     valid_q;
  logic [LANE_N*DATA_W-1:0] data_q;
  logic [LANE_N*DATA_W-1:0] data_d;
  logic [LANE_N*DATA_W-1:0] res_q;
  logic [LANE_N*DATA_W-1:0] res_d;
  logic [BLK_W-1:0]         blk;
  logic [TMP_W-1:0]         tmp;

  // The sequence counter wraps after the drain count. ready is computed
  // from the next count so that the registered ready_q always equals
  // (seq_q != SEQ_LAST) in the same cycle, with no extra decode after the
  // flop.
  always_comb begin
    seq_d   = (seq_q == SEQ_LAST) ? '0 : seq_q + 1'b1;
    ready_d = (seq_d != SEQ_LAST);
  end

  // Per-lane datapath. The residual holds 2*seq_q valid bits, LSB-aligned,
  // so the fill level comes from the counter and needs no register of its
  // own. A new block is shifted up past those bits and OR'd in.
  // The low word goes out now; the high word becomes the new residual.
  // On the drain count the residual is exactly one full word. It is sent
  // as-is and the incoming lanes are ignored, so data_i/head_i from a
  // stall cycle never reach any state.
  always_comb begin
    data_d = '0;
    res_d  = '0;
    blk    = '0;
    tmp    = '0;
    for (int l = 0; l < LANE_N; l++) begin
      blk = {data_i[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]};
      if (seq_q == SEQ_LAST) begin
        data_d[l*DATA_W +: DATA_W] = res_q[l*DATA_W +: DATA_W];
      end else begin
        tmp = (TMP_W'(blk) << (seq_q * HEAD_W))
            | TMP_W'(res_q[l*DATA_W +: DATA_W]);
        data_d[l*DATA_W +: DATA_W] = tmp[DATA_W-1:0];
        res_d[l*DATA_W +: DATA_W]  = tmp[TMP_W-1:DATA_W];
      end
    end
  end

  // All state and outputs are registered. Reset discards any partial
  // residual so that the first block after reset starts at data_o bit 0.
  // valid_q is set on the first edge out of reset and stays set, because
  // the gearbox emits a word every cycle from then on.
  always_ff @(posedge clk) begin
    if (nreset) begin
      seq_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      res_q   <= '0;
    end else begin
      seq_q   <= seq_d;
      ready_q <= ready_d;
      valid_q <= 1'b1;
      data_q  <= data_d;
      res_q   <= res_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign seq_o   = seq_q;

endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// tb_pcs_tx_gearbox
//
// Self-checking bench for pcs_tx_gearbox. The scoreboard is a queue with
// one entry per transmitted bit position. Each entry is a LANE_N-bit vector
// holding that bit for every lane. Every accepted 66-bit block pushes 66
// entries. Every valid output word pops 64 entries. Because the queue only
// records the order of the accepted bits, the expected output is the plain
// concatenation of those bits, which the design must reproduce.

module tb_pcs_tx_gearbox;

  localparam int LANE_N = 4;
  localparam int DATA_W = 64;
  localparam int HEAD_W = 2;
  localparam int SEQ_W  = 6;
  localparam int BLK_W  = DATA_W + HEAD_W;
  localparam int PERIOD = 33;

  logic                     clk;
  logic                     nreset;
  logic [LANE_N*HEAD_W-1:0] head_i;
  logic [LANE_N*DATA_W-1:0] data_i;
  logic                     ready_o;
  logic [LANE_N*DATA_W-1:0] data_o;
  logic                     valid_o;
  logic [SEQ_W-1:0]         seq_o;

  logic [LANE_N-1:0] sb [$];
  int checks;
  int passes;
  int expSeq;
  logic expValid;
  logic expReady;

  pcs_tx_gearbox #(
    .LANE_N(LANE_N),
    .DATA_W(DATA_W),
    .HEAD_W(HEAD_W),
    .SEQ_W (SEQ_W)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .head_i (head_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .seq_o  (seq_o)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the design or the bench stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired passed=%0d total=%0d", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [LANE_N*DATA_W-1:0] randData();
    logic [LANE_N*DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANE_N * DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drives one cycle. The call starts just after a falling edge and ends
  // on the next falling edge. Blocks are pushed to the scoreboard when the
  // model says they will be accepted. Reset flushes everything pending.
  task automatic tick(input logic rst, input logic [LANE_N*HEAD_W-1:0] h,
                      input logic [LANE_N*DATA_W-1:0] d);
    logic [LANE_N-1:0] e;
    nreset = rst;
    head_i = h;
    data_i = d;
    if (rst) begin
      sb.delete();
    end else if (expReady) begin
      for (int b = 0; b < BLK_W; b++) begin
        for (int l = 0; l < LANE_N; l++) begin
          if (b < HEAD_W) e[l] = h[l*HEAD_W + b];
          else            e[l] = d[l*DATA_W + b - HEAD_W];
        end
        sb.push_back(e);
      end
    end
    @(posedge clk);
    if (rst) begin
      expSeq   = 0;
      expValid = 1'b0;
      expReady = 1'b1;
    end else begin
      expSeq   = (expSeq == PERIOD - 1) ? 0 : expSeq + 1;
      expValid = 1'b1;
      expReady = (expSeq != PERIOD - 1);
    end
    @(negedge clk);
  endtask

  // Pulls the next expected output word off the scoreboard. ok is cleared
  // if too few bits were queued.
  task automatic popWord(output logic [LANE_N*DATA_W-1:0] w, output bit ok);
    logic [LANE_N-1:0] e;
    w  = '0;
    ok = (sb.size() >= DATA_W);
    if (ok) begin
      for (int b = 0; b < DATA_W; b++) begin
        e = sb.pop_front();
        for (int l = 0; l < LANE_N; l++) w[l*DATA_W + b] = e[l];
      end
    end
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, '0, '0);
  endtask

  task automatic test_reset();
    doReset(3);
    checks++;
    if (seq_o !== '0) $display("[TB] FAIL reset_seq got=%0d exp=0", seq_o);
    else passes++;
    checks++;
    if (ready_o !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", ready_o);
    else passes++;
    checks++;
    if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid got=%b exp=0", valid_o);
    else passes++;
    checks++;
    if (data_o !== '0) $display("[TB] FAIL reset_data got=%h exp=0", data_o);
    else passes++;
  endtask

  task automatic test_constant_header();
    logic [LANE_N*DATA_W-1:0] w;
    logic [DATA_W-1:0] one;
    logic [DATA_W-1:0] lane;
    bit ok;
    int k;
    doReset(2);
    one = 1;
    for (int c = 1; c <= 40; c++) begin
      tick(1'b0, {LANE_N{2'b01}}, '0);
      k = (c - 1) % PERIOD;
      lane = (k == PERIOD - 1) ? '0 : one << (2 * k);
      checks++;
      if (data_o !== {LANE_N{lane}})
        $display("[TB] FAIL const_hdr cycle=%0d got=%h exp=%h", c, data_o, {LANE_N{lane}});
      else passes++;
      popWord(w, ok);
      checks++;
      if (!ok || data_o !== w)
        $display("[TB] FAIL const_sb cycle=%0d got=%h exp=%h", c, data_o, w);
      else passes++;
    end
  endtask

  task automatic test_ready_pattern();
    logic [LANE_N*DATA_W-1:0] w;
    bit ok;
    logic expRdy;
    doReset(2);
    for (int c = 1; c <= 200; c++) begin
      tick(1'b0, LANE_N*HEAD_W'($urandom), randData());
      expRdy = ((c % PERIOD) != PERIOD - 1);
      checks++;
      if (ready_o !== expRdy)
        $display("[TB] FAIL ready_pat cycle=%0d got=%b exp=%b", c, ready_o, expRdy);
      else passes++;
      checks++;
      if (seq_o !== SEQ_W'(c % PERIOD))
        $display("[TB] FAIL seq_pat cycle=%0d got=%0d exp=%0d", c, seq_o, c % PERIOD);
      else passes++;
      checks++;
      if (valid_o !== 1'b1)
        $display("[TB] FAIL valid_run cycle=%0d got=%b exp=1", c, valid_o);
      else passes++;
      popWord(w, ok);
      checks++;
      if (!ok || data_o !== w)
        $display("[TB] FAIL ready_sb cycle=%0d got=%h exp=%h", c, data_o, w);
      else passes++;
    end
  endtask

  task automatic test_random_stream();
    logic [LANE_N*DATA_W-1:0] w;
    bit ok;
    doReset(2);
    for (int c = 1; c <= 10 * PERIOD; c++) begin
      tick(1'b0, LANE_N*HEAD_W'($urandom), randData());
      popWord(w, ok);
      checks++;
      if (!ok || data_o !== w)
        $display("[TB] FAIL random_sb cycle=%0d got=%h exp=%h", c, data_o, w);
      else passes++;
    end
    checks++;
    if (sb.size() != 0)
      $display("[TB] FAIL random_drain leftover=%0d exp=0", sb.size());
    else passes++;
  endtask

  task automatic test_stall_ignore();
    logic [LANE_N*DATA_W-1:0] w;
    logic [LANE_N*DATA_W-1:0] oddMask;
    bit ok;
    doReset(2);
    oddMask = {(LANE_N*DATA_W/2){2'b10}};
    for (int c = 1; c <= 70; c++) begin
      if (expReady) tick(1'b0, {LANE_N{2'b01}}, '0);
      else          tick(1'b0, '1, '1);
      checks++;
      if ((data_o & oddMask) !== '0)
        $display("[TB] FAIL stall_garbage cycle=%0d got=%h", c, data_o);
      else passes++;
      popWord(w, ok);
      checks++;
      if (!ok || data_o !== w)
        $display("[TB] FAIL stall_sb cycle=%0d got=%h exp=%h", c, data_o, w);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    logic [LANE_N*DATA_W-1:0] w;
    logic [2*LANE_N-1:0] hdrs;
    bit ok;
    bit found;
    doReset(2);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b0, LANE_N*HEAD_W'($urandom), randData());
      if (seq_o === SEQ_W'(17)) found = 1'b1;
    end
    checks++;
    if (!found) $display("[TB] FAIL midrst_reach seq got=%0d exp=17", seq_o);
    else passes++;
    tick(1'b1, '1, '1);
    checks++;
    if (seq_o !== '0) $display("[TB] FAIL midrst_seq got=%0d exp=0", seq_o);
    else passes++;
    checks++;
    if (ready_o !== 1'b1) $display("[TB] FAIL midrst_ready got=%b exp=1", ready_o);
    else passes++;
    checks++;
    if (valid_o !== 1'b0) $display("[TB] FAIL midrst_valid got=%b exp=0", valid_o);
    else passes++;
    checks++;
    if (data_o !== '0) $display("[TB] FAIL midrst_data got=%h exp=0", data_o);
    else passes++;
    for (int c = 1; c <= 6; c++) begin
      tick(1'b0, (c == 1) ? {LANE_N{2'b10}} : LANE_N*HEAD_W'($urandom), randData());
      if (c == 1) begin
        for (int l = 0; l < LANE_N; l++) hdrs[l*2 +: 2] = data_o[l*DATA_W +: 2];
        checks++;
        if (hdrs !== {LANE_N{2'b10}})
          $display("[TB] FAIL midrst_hdr got=%b exp=%b", hdrs, {LANE_N{2'b10}});
        else passes++;
      end
      popWord(w, ok);
      checks++;
      if (!ok || data_o !== w)
        $display("[TB] FAIL midrst_sb cycle=%0d got=%h exp=%h", c, data_o, w);
      else passes++;
    end
  endtask

  task automatic test_lane_patterns();
    logic [LANE_N*DATA_W-1:0] w;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] bad;
    bit ok;
    doReset(2);
    for (int c = 1; c <= 40; c++) begin
      tick(1'b0, 8'b10_01_10_01, '0);
      for (int l = 0; l < LANE_N; l++) begin
        lane = data_o[l*DATA_W +: DATA_W];
        bad  = (l % 2 == 0) ? (lane & {(DATA_W/2){2'b10}}) : (lane & {(DATA_W/2){2'b01}});
        checks++;
        if (bad !== '0)
          $display("[TB] FAIL lane_pattern cycle=%0d lane=%0d got=%h", c, l, lane);
        else passes++;
      end
      checks++;
      if (ready_o !== expReady)
        $display("[TB] FAIL lane_ready cycle=%0d got=%b exp=%b", c, ready_o, expReady);
      else passes++;
      popWord(w, ok);
      checks++;
      if (!ok || data_o !== w)
        $display("[TB] FAIL lane_sb cycle=%0d got=%h exp=%h", c, data_o, w);
      else passes++;
    end
  endtask

  // Runs every scenario in order, then prints the single summary line.
  initial begin
    checks   = 0;
    passes   = 0;
    expSeq   = 0;
    expValid = 1'b0;
    expReady = 1'b1;
    nreset   = 1'b1;
    head_i   = '0;
    data_i   = '0;
    test_reset();
    test_constant_header();
    test_ready_pattern();
    test_random_stream();
    test_stall_ignore();
    test_mid_reset();
    test_lane_patterns();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
